// File: rtl/digit_overlay_pkg.sv
// Shared code constants, segment indices and the 7-segment mask table for the digit overlay.
package digit_overlay_pkg;

    localparam logic [3:0] CODE_INVALID = 4'd11;
    localparam logic [3:0] CODE_PLUS    = 4'd12;
    localparam logic [3:0] CODE_MINUS   = 4'd13;
    localparam logic [3:0] CODE_TIMES   = 4'd14;
    localparam logic [3:0] CODE_DIV     = 4'd15;

    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_idx_e;

    // Bit n of the mask lights segment seg_idx_e'(n); codes 10 and 11 both draw an "E".
    function automatic logic [6:0] seg_mask(input logic [3:0] code);
        logic [6:0] m;
        m = 7'h00;
        case (code)
            4'd0:         m = 7'h3F;
            4'd1:         m = 7'h06;
            4'd2:         m = 7'h5B;
            4'd3:         m = 7'h4F;
            4'd4:         m = 7'h66;
            4'd5:         m = 7'h6D;
            4'd6:         m = 7'h7D;
            4'd7:         m = 7'h07;
            4'd8:         m = 7'h7F;
            4'd9:         m = 7'h6F;
            4'd10:        m = 7'h79;
            CODE_INVALID: m = 7'h79;
            default:      m = 7'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/digit_glyph_hit.sv
// Combinational glyph rasteriser: decides whether local cell pixel (u,v) is ink for a given code.
module digit_glyph_hit
    import digit_overlay_pkg::*;
#(
    parameter int W = 24,
    parameter int H = 48,
    parameter int T = 4
) (
    input  logic [3:0]  code,
    input  logic [10:0] u,
    input  logic [9:0]  v,
    output logic        ink
);

    int         ui;
    int         vi;
    logic [6:0] seg;
    logic       mid_col;
    logic       vbar;
    logic       dots;
    logic       diag;

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    always_comb begin
        ui = {21'd0, u};
        vi = {22'd0, v};

        seg        = '0;
        seg[SEG_A] = (vi < T);
        seg[SEG_D] = (vi >= H - T);
        seg[SEG_G] = (vi >= H/2 - T/2) && (vi < H/2 + T/2);
        seg[SEG_F] = (ui < T) && (vi < H/2);
        seg[SEG_E] = (ui < T) && (vi >= H/2);
        seg[SEG_B] = (ui >= W - T) && (vi < H/2);
        seg[SEG_C] = (ui >= W - T) && (vi >= H/2);

        // Operator strokes share the centre column used by the plus bar and divide dots.
        mid_col = (ui >= W/2 - T/2) && (ui < W/2 + T/2);
        vbar    = mid_col && (vi >= H/4) && (vi < 3*H/4);
        dots    = mid_col && (((vi >= H/4 - T/2) && (vi < H/4 + T/2)) ||
                              ((vi >= 3*H/4 - T/2) && (vi < 3*H/4 + T/2)));
        diag    = (iabs(2*ui - vi) < 2*T) || (iabs(2*ui - (H - 1 - vi)) < 2*T);

        case (code)
            CODE_PLUS:  ink = seg[SEG_G] || vbar;
            CODE_MINUS: ink = seg[SEG_G];
            CODE_TIMES: ink = diag;
            CODE_DIV:   ink = seg[SEG_G] || dots;
            default:    ink = |(seg_mask(code) & seg);
        endcase
    end

endmodule

// File: rtl/digit_overlay_renderer.sv
// Buffers recognised codes and overlays them as glyphs on the pixel stream with 2-cycle latency.
// Define DIGIT_OVERLAY_BOX_EN to draw a BOX_COLOR border around every occupied cell.
module digit_overlay_renderer
    import digit_overlay_pkg::*;
#(
    parameter int          ORIGIN_X = 16,
    parameter int          ORIGIN_Y = 16,
    parameter int          CELL_W   = 24,
    parameter int          CELL_H   = 48,
    parameter int          GAP      = 8,
    parameter int          SLOTS    = 4,
    parameter int          SEG_T    = 4,
`ifdef DIGIT_OVERLAY_BOX_EN
    parameter logic [23:0] BOX_COLOR = 24'h00FF00,
`endif
    parameter logic [23:0] FG_COLOR  = 24'h0000FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] RGB_Data_Src,
    input  logic [10:0] RGB_x_Src,
    input  logic [9:0]  RGB_y_Src,
    input  logic [3:0]  num,
    input  logic        num_valid,
    input  logic        clear,
    output logic [23:0] RGB_Data_Dst,
    output logic [10:0] RGB_x_Dst,
    output logic [9:0]  RGB_y_Dst,
    output logic [3:0]  fill_cnt
);

    logic [3:0]  slots_q [SLOTS];
    logic [3:0]  slots_d [SLOTS];
    logic [3:0]  fill_q, fill_d, fill_eff;
    logic [3:0]  shadow_slots_q [SLOTS];
    logic [3:0]  shadow_slots_d [SLOTS];
    logic [3:0]  shadow_fill_q, shadow_fill_d;

    logic [2:0]  slot_p1_q, slot_p1_d;
    logic        in_cell_p1_q, in_cell_p1_d;
    logic [10:0] u_p1_q, u_p1_d;
    logic [9:0]  v_p1_q, v_p1_d;
    logic [23:0] data_p1_q, data_p1_d;
    logic [10:0] x_p1_q, x_p1_d;
    logic [9:0]  y_p1_q, y_p1_d;

    logic [23:0] data_p2_q, data_p2_d;
    logic [10:0] x_p2_q, x_p2_d;
    logic [9:0]  y_p2_q, y_p2_d;

    int          xi, yi, x0;
    logic [3:0]  code_sel;
    logic        occupied;
    logic        glyph_ink;

    // Code buffer: clear takes effect before a same-cycle push.
    always_comb begin
        fill_eff = clear ? 4'd0 : fill_q;
        slots_d  = slots_q;
        fill_d   = fill_eff;
        if (num_valid) begin
            if (fill_eff < 4'(SLOTS)) begin
                for (int i = 0; i < SLOTS; i++) begin
                    if (fill_eff == 4'(i)) slots_d[i] = num;
                end
                fill_d = fill_eff + 4'd1;
            end else begin
                for (int i = 0; i < SLOTS - 1; i++) slots_d[i] = slots_q[i+1];
                slots_d[SLOTS-1] = num;
            end
        end
    end

    always_comb begin
        shadow_slots_d = shadow_slots_q;
        shadow_fill_d  = shadow_fill_q;
        if (RGB_x_Src == 11'd0 && RGB_y_Src == 10'd0) begin
            shadow_slots_d = slots_q;
            shadow_fill_d  = fill_q;
        end
    end

    // Stage 1: locate the cell under the incoming pixel and its local coordinates.
    always_comb begin
        xi           = {21'd0, RGB_x_Src};
        yi           = {22'd0, RGB_y_Src};
        x0           = 0;
        slot_p1_d    = '0;
        in_cell_p1_d = 1'b0;
        u_p1_d       = '0;
        v_p1_d       = '0;
        for (int i = 0; i < SLOTS; i++) begin
            x0 = ORIGIN_X + i * (CELL_W + GAP);
            if (xi >= x0 && xi < x0 + CELL_W && yi >= ORIGIN_Y && yi < ORIGIN_Y + CELL_H) begin
                in_cell_p1_d = 1'b1;
                slot_p1_d    = 3'(i);
                u_p1_d       = 11'(xi - x0);
                v_p1_d       = 10'(yi - ORIGIN_Y);
            end
        end
        data_p1_d = RGB_Data_Src;
        x_p1_d    = RGB_x_Src;
        y_p1_d    = RGB_y_Src;
    end

    // Stage 2: shadow lookup, glyph hit and colour mux.
    always_comb begin
        code_sel = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_p1_q == 3'(i)) code_sel = shadow_slots_q[i];
        end
        occupied  = in_cell_p1_q && ({1'b0, slot_p1_q} < shadow_fill_q);
        data_p2_d = data_p1_q;
        if (occupied && glyph_ink) data_p2_d = FG_COLOR;
`ifdef DIGIT_OVERLAY_BOX_EN
        if (occupied && (u_p1_q == 11'd0 || u_p1_q == 11'(CELL_W - 1) ||
                         v_p1_q == 10'd0 || v_p1_q == 10'(CELL_H - 1)))
            data_p2_d = BOX_COLOR;
`endif
        x_p2_d = x_p1_q;
        y_p2_d = y_p1_q;
    end

    digit_glyph_hit #(
        .W (CELL_W),
        .H (CELL_H),
        .T (SEG_T)
    ) u_glyph (
        .code (code_sel),
        .u    (u_p1_q),
        .v    (v_p1_q),
        .ink  (glyph_ink)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                slots_q[i]        <= '0;
                shadow_slots_q[i] <= '0;
            end
            fill_q        <= '0;
            shadow_fill_q <= '0;
            slot_p1_q     <= '0;
            in_cell_p1_q  <= 1'b0;
            u_p1_q        <= '0;
            v_p1_q        <= '0;
            data_p1_q     <= '0;
            x_p1_q        <= '0;
            y_p1_q        <= '0;
            data_p2_q     <= '0;
            x_p2_q        <= '0;
            y_p2_q        <= '0;
        end else begin
            slots_q        <= slots_d;
            fill_q         <= fill_d;
            shadow_slots_q <= shadow_slots_d;
            shadow_fill_q  <= shadow_fill_d;
            slot_p1_q      <= slot_p1_d;
            in_cell_p1_q   <= in_cell_p1_d;
            u_p1_q         <= u_p1_d;
            v_p1_q         <= v_p1_d;
            data_p1_q      <= data_p1_d;
            x_p1_q         <= x_p1_d;
            y_p1_q         <= y_p1_d;
            data_p2_q      <= data_p2_d;
            x_p2_q         <= x_p2_d;
            y_p2_q         <= y_p2_d;
        end
    end

    assign RGB_Data_Dst = data_p2_q;
    assign RGB_x_Dst    = x_p2_q;
    assign RGB_y_Dst    = y_p2_q;
    assign fill_cnt     = fill_q;

endmodule

// File: tb/tb_digit_overlay_renderer.sv
// Directed bench for digit_overlay_renderer with hand-computed pixel expectations.
module tb_digit_overlay_renderer;

    localparam logic [23:0] SRC  = 24'h123456;
    localparam logic [23:0] INK  = 24'h0000FF;
`ifdef DIGIT_OVERLAY_BOX_EN
    localparam logic [23:0] CORNER_INK  = 24'h00FF00;
    localparam logic [23:0] CORNER_PASS = 24'h00FF00;
`else
    localparam logic [23:0] CORNER_INK  = INK;
    localparam logic [23:0] CORNER_PASS = SRC;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] RGB_Data_Src;
    logic [10:0] RGB_x_Src;
    logic [9:0]  RGB_y_Src;
    logic [3:0]  num;
    logic        num_valid;
    logic        clear;
    logic [23:0] RGB_Data_Dst;
    logic [10:0] RGB_x_Dst;
    logic [9:0]  RGB_y_Dst;
    logic [3:0]  fill_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    digit_overlay_renderer dut (
        .clk          (clk),
        .rst          (rst),
        .RGB_Data_Src (RGB_Data_Src),
        .RGB_x_Src    (RGB_x_Src),
        .RGB_y_Src    (RGB_y_Src),
        .num          (num),
        .num_valid    (num_valid),
        .clear        (clear),
        .RGB_Data_Dst (RGB_Data_Dst),
        .RGB_x_Dst    (RGB_x_Dst),
        .RGB_y_Dst    (RGB_y_Dst),
        .fill_cnt     (fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_pix();
        RGB_x_Src = 11'd1000;
        RGB_y_Src = 10'd500;
    endtask

    task automatic frame_start();
        RGB_x_Src = 11'd0;
        RGB_y_Src = 10'd0;
        step();
        idle_pix();
    endtask

    task automatic push(input logic [3:0] n, input logic with_clear);
        num       = n;
        num_valid = 1'b1;
        clear     = with_clear;
        step();
        num_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [23:0] exp);
        RGB_x_Src = 11'(x);
        RGB_y_Src = 10'(y);
        step();
        idle_pix();
        step();
        check(tag, {8'd0, RGB_Data_Dst}, {8'd0, exp});
    endtask

    initial begin
        rst          = 1'b1;
        RGB_Data_Src = SRC;
        num          = '0;
        num_valid    = 1'b0;
        clear        = 1'b0;
        idle_pix();
        step();
        step();
        check("rst_data", {8'd0, RGB_Data_Dst}, 32'd0);
        check("rst_x", {21'd0, RGB_x_Dst}, 32'd0);
        check("rst_y", {22'd0, RGB_y_Dst}, 32'd0);
        check("rst_fill", {28'd0, fill_cnt}, 32'd0);
        rst = 1'b0;
        step();

        push(4'd8, 1'b0);
        check("fill_after_8", {28'd0, fill_cnt}, 32'd1);
        frame_start();
        probe("eight_a_f", 18, 17, INK);
        check("x_delay", {21'd0, RGB_x_Dst}, 32'd18);
        check("y_delay", {22'd0, RGB_y_Dst}, 32'd17);
        probe("eight_g", 30, 40, INK);
        probe("eight_hole", 28, 20, SRC);
        probe("gap_pass", 40, 20, SRC);
        probe("eight_corner", 16, 16, CORNER_INK);
        probe("slot1_empty_corner", 48, 16, SRC);

        do_clear();
        check("fill_clear", {28'd0, fill_cnt}, 32'd0);
        push(4'd1, 1'b0);
        check("fill_after_1", {28'd0, fill_cnt}, 32'd1);
        frame_start();
        probe("one_no_f", 17, 20, SRC);
        probe("one_b", 38, 20, INK);

        do_clear();
        for (int i = 0; i < 5; i++) push(4'(i), 1'b0);
        check("fill_full", {28'd0, fill_cnt}, 32'd4);
        frame_start();
        probe("s0_one_b", 38, 20, INK);
        probe("s0_one_no_f", 17, 20, SRC);
        probe("s1_two_e", 49, 46, INK);
        probe("s3_four_f", 113, 20, INK);
        probe("s3_four_no_a", 125, 17, SRC);

        push(4'd5, 1'b0);
        check("fill_shift", {28'd0, fill_cnt}, 32'd4);
        probe("old_shadow_s0", 17, 46, SRC);
        frame_start();
        probe("new_shadow_s0_two_e", 17, 46, INK);
        probe("s3_five_f", 113, 20, INK);
        probe("s3_five_no_b", 134, 20, SRC);

        push(4'd12, 1'b1);
        check("fill_clear_push", {28'd0, fill_cnt}, 32'd1);
        frame_start();
        probe("plus_bar", 28, 31, INK);
        probe("plus_no_f", 17, 20, SRC);
        probe("plus_corner", 16, 16, CORNER_PASS);
        probe("plus_slot1_empty", 49, 17, SRC);

        push(4'd14, 1'b1);
        frame_start();
        probe("times_corner", 16, 16, CORNER_INK);
        probe("times_centre", 28, 40, INK);
        probe("times_diag", 22, 28, INK);
        probe("times_off", 17, 40, SRC);
        probe("times_off2", 22, 40, SRC);

        push(4'd11, 1'b1);
        frame_start();
        probe("inval_f", 17, 20, INK);
        probe("inval_no_b", 38, 20, SRC);

        push(4'd15, 1'b1);
        frame_start();
        probe("div_dot", 28, 28, INK);
        probe("div_between", 28, 20, SRC);
        probe("div_g", 20, 40, INK);

        rst = 1'b1;
        #1;
        check("midrst_fill", {28'd0, fill_cnt}, 32'd0);
        check("midrst_data", {8'd0, RGB_Data_Dst}, 32'd0);
        step();
        rst = 1'b0;
        step();
        probe("after_rst_pass", 28, 28, SRC);
        probe("after_rst_pass2", 20, 40, SRC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
